alupipe_result_checker: RTL and testbench

Synthesizable response checker for the pipelined 32-bit ALU. It is the receiving end of the ALU stimulus stream: the stimulus source presents each vector's expected result in the same cycle it drives abus/bbus/S/Cin. The checker delays that expectation through a pipeline matched to ALU latency, compares it against dbus, and accumulates a pass/fail summary. It sits beside alupipe in the on-board self-test wrapper and replaces bench-only reference comparison in hardware.

---
 rtl/alupipe_chk_pkg.sv | 29 ++
 rtl/alupipe_chk_delay.sv | 58 +++++
 rtl/alupipe_result_checker.sv | 153 +++++++++++++++
 tb/tb_alupipe_result_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alupipe_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alupipe_chk_pkg
// Description : Shared types and constants for the alupipe result checker
//               and the stimulus sources that feed it.
// Revision    : 1.0 - initial release
// ============================================================================
package alupipe_chk_pkg;

  localparam int c_alupipe_latency = 2;

  // ALU opcodes, so stimulus sources and checkers use the same encoding
  localparam logic [2:0] c_op_xor  = 3'b000;
  localparam logic [2:0] c_op_xnor = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_sub  = 3'b011;
  localparam logic [2:0] c_op_or   = 3'b100;
  localparam logic [2:0] c_op_nor  = 3'b101;
  localparam logic [2:0] c_op_and  = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/alupipe_chk_delay.sv
`default_nettype none
// ============================================================================
// Module      : alupipe_chk_delay
// Description : LATENCY-deep shift register of {valid, exp, mask, idx} that
//               aligns issued expectations with the ALU result bus.
// Revision    : 1.0 - initial release
// ============================================================================
module alupipe_chk_delay #(
  parameter int LATENCY = 2,
  parameter int W       = 32,
  parameter int IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_exp,
  input  logic [W-1:0]     in_mask,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [W-1:0]     out_exp,
  output logic [W-1:0]     out_mask,
  output logic [IDX_W-1:0] out_idx
);

  logic [LATENCY-1:0]            r_valid;
  logic [LATENCY-1:0][W-1:0]     r_exp;
  logic [LATENCY-1:0][W-1:0]     r_mask;
  logic [LATENCY-1:0][IDX_W-1:0] r_idx;

  // Only the valid bits need clearing; stale payload is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_exp   <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
    end else begin
      r_valid[0] <= in_valid & ~clr;
      r_exp[0]   <= in_exp;
      r_mask[0]  <= in_mask;
      r_idx[0]   <= in_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1] & ~clr;
        r_exp[i]   <= r_exp[i-1];
        r_mask[i]  <= r_mask[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign out_valid = r_valid[LATENCY-1];
  assign out_exp   = r_exp[LATENCY-1];
  assign out_mask  = r_mask[LATENCY-1];
  assign out_idx   = r_idx[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/alupipe_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : alupipe_result_checker
// Description : Delays each issued expectation to match ALU latency, compares
//               it against dbus under a bit mask and keeps a pass/fail summary.
// Revision    : 1.0 - initial release
// ============================================================================
module alupipe_result_checker
  import alupipe_chk_pkg::*;
#(
  parameter int LATENCY = c_alupipe_latency,
  parameter int W       = 32,
  parameter int ERR_W   = 16,
  parameter int IDX_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             vec_last,
  input  logic [W-1:0]     vec_exp,
  input  logic [W-1:0]     vec_mask,
  input  logic [W-1:0]     dbus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] vec_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [W-1:0]     first_err_got,
  output logic [W-1:0]     first_err_exp
);

  localparam logic [3:0] c_drain_load = 4'(LATENCY);

  chk_state_t       r_state;
  logic [3:0]       r_drain;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [IDX_W-1:0] r_issue_idx;
  logic [ERR_W-1:0] r_err_count;
  logic [IDX_W-1:0] r_vec_count;
  logic [IDX_W-1:0] r_first_idx;
  logic [W-1:0]     r_first_got;
  logic [W-1:0]     r_first_exp;

  logic             w_accept;
  logic             w_cmp_valid;
  logic [W-1:0]     w_cmp_exp;
  logic [W-1:0]     w_cmp_mask;
  logic [IDX_W-1:0] w_cmp_idx;
  logic             w_mismatch;

  // start wins over a vector presented in the same cycle
  assign w_accept   = (r_state == RUN) & vec_valid & ~start;
  assign w_mismatch = |((dbus ^ w_cmp_exp) & w_cmp_mask);

  alupipe_chk_delay #(
    .LATENCY (LATENCY),
    .W       (W),
    .IDX_W   (IDX_W)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start),
    .in_valid  (w_accept),
    .in_exp    (vec_exp),
    .in_mask   (vec_mask),
    .in_idx    (r_issue_idx),
    .out_valid (w_cmp_valid),
    .out_exp   (w_cmp_exp),
    .out_mask  (w_cmp_mask),
    .out_idx   (w_cmp_idx)
  );

  // DRAIN holds one cycle past the final compare so pass sees its error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_drain     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_issue_idx <= '0;
    end else if (start) begin
      r_state     <= RUN;
      r_drain     <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_issue_idx <= '0;
    end else begin
      if (w_accept) r_issue_idx <= r_issue_idx + 1'b1;
      case (r_state)
        RUN: begin
          if (w_accept && vec_last) begin
            r_state <= DRAIN;
            r_drain <= c_drain_load;
          end
        end
        DRAIN: begin
          if (r_drain == 4'd0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == '0);
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_vec_count <= '0;
      r_first_idx <= '0;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else if (start) begin
      r_err_count <= '0;
      r_vec_count <= '0;
      r_first_idx <= '0;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else if (w_cmp_valid) begin
      r_vec_count <= r_vec_count + 1'b1;
      if (w_mismatch) begin
        if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        if (r_err_count == '0) begin
          r_first_idx <= w_cmp_idx;
          r_first_got <= dbus;
          r_first_exp <= w_cmp_exp;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign vec_count     = r_vec_count;
  assign first_err_idx = r_first_idx;
  assign first_err_got = r_first_got;
  assign first_err_exp = r_first_exp;

endmodule
`default_nettype wire

// File: tb/tb_alupipe_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_alupipe_result_checker
// Description : Directed, table-driven self-checking bench for the checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alupipe_result_checker;
  import alupipe_chk_pkg::*;

  localparam int LAT = c_alupipe_latency;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         vec_valid = 1'b0;
  logic         vec_last = 1'b0;
  logic [W-1:0] vec_exp = '0;
  logic [W-1:0] vec_mask = '0;
  logic [W-1:0] got_in = '0;
  logic [W-1:0] dbus;
  logic [W-1:0] pipe [LAT];

  logic         busy, done, pass;
  logic [15:0]  err_count, vec_count, first_err_idx;
  logic [W-1:0] first_err_got, first_err_exp;

  logic         s_busy, s_done, s_pass;
  logic [1:0]   s_err_count;
  logic [15:0]  s_vec_count, s_first_err_idx;
  logic [W-1:0] s_first_err_got, s_first_err_exp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] exp;
    logic [W-1:0] mask;
    logic [W-1:0] got;
    logic         last;
    logic [15:0]  want_err;
    logic [15:0]  want_vcnt;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  // ALU result path model: the result of a vector issued on edge E appears on
  // dbus in time to be sampled on edge E+LAT.
  always @(posedge clk) begin
    pipe[0] <= vec_valid ? got_in : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dbus = pipe[LAT-1];

  alupipe_result_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_last(vec_last), .vec_exp(vec_exp), .vec_mask(vec_mask), .dbus(dbus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_count(vec_count), .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp)
  );

  alupipe_result_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_last(vec_last), .vec_exp(vec_exp), .vec_mask(vec_mask), .dbus(dbus),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .vec_count(s_vec_count), .first_err_idx(s_first_err_idx),
    .first_err_got(s_first_err_got), .first_err_exp(s_first_err_exp)
  );

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic cin);
    case (op)
      c_op_xor:  return a ^ b;
      c_op_xnor: return ~(a ^ b);
      c_op_add:  return a + b + {31'b0, cin};
      c_op_sub:  return a + ~b + {31'b0, cin};
      c_op_or:   return a | b;
      c_op_nor:  return ~(a | b);
      c_op_and:  return a & b;
      default:   return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] exp, input logic [W-1:0] mask,
                       input logic [W-1:0] got, input logic last);
    vec_valid = 1'b1;
    vec_last  = last;
    vec_exp   = exp;
    vec_mask  = mask;
    got_in    = got;
    tick();
    vec_valid = 1'b0;
    vec_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", {31'b0, done}, 32'd1);
  endtask

  initial begin
    tbl[0] = '{32'h000000FF, 32'hFFFFFFFF, 32'h000000FF, 1'b0, 16'd0, 16'd1};
    tbl[1] = '{32'h00100166, 32'hFFFFFFFF, 32'h00100167, 1'b0, 16'd1, 16'd2};
    tbl[2] = '{32'h00000000, 32'h00000000, 32'h12345678, 1'b0, 16'd1, 16'd3};
    tbl[3] = '{32'hAAAA1234, 32'h0000FFFF, 32'h55551234, 1'b0, 16'd1, 16'd4};
    tbl[4] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000003, 1'b0, 16'd2, 16'd5};
    tbl[5] = '{32'h00000007, 32'hFFFFFFFF, 32'h00000007, 1'b1, 16'd2, 16'd6};

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pass", {31'b0, pass}, 32'd0);
    chk("rst_err", {16'b0, err_count}, 32'd0);
    chk("rst_vcnt", {16'b0, vec_count}, 32'd0);
    chk("rst_first_got", first_err_got, 32'd0);

    // vec_valid in IDLE is ignored
    issue(32'h1, 32'hFFFFFFFF, 32'h2, 1'b1);
    repeat (LAT + 1) tick();
    chk("idle_vcnt", {16'b0, vec_count}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Clean run, three back-to-back adds through the ALU model
    pulse_start();
    chk("run_busy", {31'b0, busy}, 32'd1);
    issue(32'h64424220, 32'hFFFFFFFF, alu(c_op_add, 32'h31312020, 32'h33112200, 1'b0), 1'b0);
    issue(32'h00000000, 32'hFFFFFFFF, alu(c_op_add, 32'hFFFFFFFF, 32'h00000000, 1'b1), 1'b0);
    issue(32'h00010000, 32'hFFFFFFFF, alu(c_op_add, 32'h0000FFFF, 32'h00000000, 1'b1), 1'b1);
    repeat (LAT) tick();
    chk("clean_done_early", {31'b0, done}, 32'd0);
    tick();
    chk("clean_done_lat1", {31'b0, done}, 32'd1);
    chk("clean_pass", {31'b0, pass}, 32'd1);
    chk("clean_err", {16'b0, err_count}, 32'd0);
    chk("clean_vcnt", {16'b0, vec_count}, 32'd3);
    chk("clean_busy", {31'b0, busy}, 32'd0);

    // vec_valid in DONE is ignored
    issue(32'h5, 32'hFFFFFFFF, 32'h6, 1'b1);
    repeat (LAT + 1) tick();
    chk("done_ign_vcnt", {16'b0, vec_count}, 32'd3);
    chk("done_ign_done", {31'b0, done}, 32'd1);

    // Restart from DONE
    pulse_start();
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_vcnt", {16'b0, vec_count}, 32'd0);
    chk("restart_busy", {31'b0, busy}, 32'd1);

    // Table: injected error, don't-care masks, later error keeps first capture
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].exp, tbl[i].mask, tbl[i].got, tbl[i].last);
      repeat (LAT) tick();
      chk($sformatf("tbl%0d_err", i), {16'b0, err_count}, {16'b0, tbl[i].want_err});
      chk($sformatf("tbl%0d_vcnt", i), {16'b0, vec_count}, {16'b0, tbl[i].want_vcnt});
    end
    tick();
    chk("tbl_done", {31'b0, done}, 32'd1);
    chk("tbl_pass", {31'b0, pass}, 32'd0);
    chk("tbl_first_idx", {16'b0, first_err_idx}, 32'd1);
    chk("tbl_first_got", first_err_got, 32'h00100167);
    chk("tbl_first_exp", first_err_exp, 32'h00100166);
    chk("tbl_sat_err", {30'b0, s_err_count}, 32'd2);

    // Saturation; a vector alongside start is dropped; one in DRAIN is ignored
    start     = 1'b1;
    vec_valid = 1'b1;
    vec_exp   = 32'h0;
    vec_mask  = 32'hFFFFFFFF;
    got_in    = 32'h1;
    tick();
    start     = 1'b0;
    vec_valid = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(32'h100 * (i + 1), 32'hFFFFFFFF, (32'h100 * (i + 1)) ^ 32'h1, i == 4);
    issue(32'h0, 32'hFFFFFFFF, 32'hF, 1'b0);
    wait_done(20);
    chk("sat_err", {30'b0, s_err_count}, 32'd3);
    chk("sat_first_idx", {16'b0, s_first_err_idx}, 32'd0);
    chk("sat_main_err", {16'b0, err_count}, 32'd5);
    chk("sat_main_vcnt", {16'b0, vec_count}, 32'd5);
    chk("sat_first_got", first_err_got, 32'h101);
    chk("sat_pass", {31'b0, pass}, 32'd0);

    // Asynchronous reset mid-RUN with a vector in flight
    pulse_start();
    issue(32'h0, 32'hFFFFFFFF, 32'h1, 1'b0);
    repeat (LAT) tick();
    chk("pre_rst_err", {16'b0, err_count}, 32'd1);
    issue(32'h0, 32'hFFFFFFFF, 32'h5, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_err", {16'b0, err_count}, 32'd0);
    chk("arst_vcnt", {16'b0, vec_count}, 32'd0);
    chk("arst_first_got", first_err_got, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT + 2) tick();
    chk("post_rst_vcnt", {16'b0, vec_count}, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_done", {31'b0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
